fir_coeff_ctrl: RTL and testbench

FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

---
 rtl/fir_ctrl_pkg.sv | 18 +
 rtl/fir_coeff_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fir_coeff_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient controller.
package fir_ctrl_pkg;

  localparam int unsigned COEFF_W = 8;
  localparam int unsigned LANES   = 4;

  // Tap 0 at full scale, all others zero: the filter passes samples through.
  localparam logic [COEFF_W-1:0] INIT_TAP0 = 8'd127;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_ARMED,
    ST_SETTLE
  } state_t;

endpackage

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: loads a shadow tap bank from an AXI-Stream,
// then swaps it into the active bank on a data-frame boundary.
//   s00_axis_aclk / s00_axis_aresetn : clock, async active-low reset
//   s00_axis_*                        : coefficient load stream (4 x 8-bit lanes)
//   mon_tvalid / mon_tready / mon_tlast : snoop of the FIR data-input handshake
//   force_swap                        : immediate swap request while armed
//   coeffs                            : active tap bank
//   settled, swap_count               : settle status and swap counter
//   err_pulse, err_count              : framing-error strobe and saturating count
module fir_coeff_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned NUM_COEFFS             = 64,
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                       s00_axis_aclk,
  input  logic                                       s00_axis_aresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]          s00_axis_tdata,
  input  logic                                       s00_axis_tvalid,
  input  logic                                       s00_axis_tlast,
  output logic                                       s00_axis_tready,
  input  logic                                       mon_tvalid,
  input  logic                                       mon_tready,
  input  logic                                       mon_tlast,
  input  logic                                       force_swap,
  output logic signed [NUM_COEFFS-1:0][COEFF_W-1:0]  coeffs,
  output logic                                       settled,
  output logic [7:0]                                 swap_count,
  output logic                                       err_pulse,
  output logic [7:0]                                 err_count
);

  localparam int unsigned BEATS    = NUM_COEFFS / LANES;
  localparam int unsigned BEAT_W   = $clog2(BEATS);
  localparam int unsigned SETTLE_W = $clog2(NUM_COEFFS + 1);
  localparam int unsigned IDX_W    = $clog2(NUM_COEFFS);

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [COEFF_W-1:0]    shadow_q [NUM_COEFFS];

  logic                  beat_hs;
  logic                  mon_hs;
  logic                  shadow_we;
  logic                  swap;
  logic                  err;
  logic                  settle_done;

  assign beat_hs = s00_axis_tvalid & s00_axis_tready;
  assign mon_hs  = mon_tvalid & mon_tready;

  // Next-state and control decode.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    settle_d    = settle_q;
    shadow_we   = 1'b0;
    swap        = 1'b0;
    err         = 1'b0;
    settle_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat_hs) begin
          shadow_we = 1'b1;
          if (s00_axis_tlast) begin
            err = 1'b1;
          end else begin
            beat_d  = BEAT_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (beat_hs) begin
          shadow_we = 1'b1;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d = '0;
            if (s00_axis_tlast) begin
              state_d = ST_ARMED;
            end else begin
              // Frame longer than the bank: flush the remainder.
              err     = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (s00_axis_tlast) begin
            err     = 1'b1;
            beat_d  = '0;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (beat_hs && s00_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // A coincident data tlast and force_swap still yields one swap.
        if ((mon_hs && mon_tlast) || force_swap) begin
          swap     = 1'b1;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (mon_hs) begin
          if (settle_q == SETTLE_W'(NUM_COEFFS - 1)) begin
            settle_done = 1'b1;
            settle_d    = '0;
            state_d     = ST_IDLE;
          end else begin
            settle_d = settle_q + SETTLE_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // State, counters and stream ready.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q         <= ST_IDLE;
      beat_q          <= '0;
      settle_q        <= '0;
      s00_axis_tready <= 1'b1;
      settled         <= 1'b1;
      swap_count      <= '0;
      err_pulse       <= 1'b0;
      err_count       <= '0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      settle_q        <= settle_d;
      s00_axis_tready <= (state_d == ST_IDLE) || (state_d == ST_LOAD) ||
                         (state_d == ST_DRAIN);
      err_pulse       <= err;
      if (err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (swap) begin
        swap_count <= swap_count + 8'd1;
        settled    <= 1'b0;
      end else if (settle_done) begin
        settled <= 1'b1;
      end
    end
  end

  // Shadow bank: each accepted load beat fills four consecutive taps.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      for (int i = 0; i < NUM_COEFFS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (shadow_we) begin
      for (int k = 0; k < LANES; k++) begin
        shadow_q[IDX_W'(int'(beat_q) * LANES + k)] <=
          s00_axis_tdata[k*COEFF_W +: COEFF_W];
      end
    end
  end

  // Active bank: changes only on a swap or reset.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      coeffs    <= '0;
      coeffs[0] <= INIT_TAP0;
    end else if (swap) begin
      for (int i = 0; i < NUM_COEFFS; i++) begin
        coeffs[i] <= shadow_q[i];
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed self-checking bench for fir_coeff_ctrl with an 8-tap bank.
module tb_fir_coeff_ctrl;

  localparam int unsigned N = 8;

  logic              clk;
  logic              rst_n;
  logic [31:0]       tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;
  logic              mvalid;
  logic              mready;
  logic              mlast;
  logic              fswap;
  logic [N-1:0][7:0] coeffs;
  logic              settled;
  logic [7:0]        swap_count;
  logic              err_pulse;
  logic [7:0]        err_count;

  int total = 0;
  int bad   = 0;

  fir_coeff_ctrl #(
    .NUM_COEFFS            (N),
    .C_S00_AXIS_TDATA_WIDTH(32)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis_tdata  (tdata),
    .s00_axis_tvalid (tvalid),
    .s00_axis_tlast  (tlast),
    .s00_axis_tready (tready),
    .mon_tvalid      (mvalid),
    .mon_tready      (mready),
    .mon_tlast       (mlast),
    .force_swap      (fswap),
    .coeffs          (coeffs),
    .settled         (settled),
    .swap_count      (swap_count),
    .err_pulse       (err_pulse),
    .err_count       (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    tdata  = d;
    tvalid = 1'b1;
    tlast  = last;
    step();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic mon_hs(input logic last);
    mvalid = 1'b1;
    mready = 1'b1;
    mlast  = last;
    step();
    mvalid = 1'b0;
    mready = 1'b0;
    mlast  = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    tdata  = '0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    mvalid = 1'b0;
    mready = 1'b0;
    mlast  = 1'b0;
    fswap  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state.
    chk("rst_coeffs", 64'(coeffs), 64'h0000_0000_0000_007F);
    chk("rst_settled", 64'(settled), 64'd1);
    chk("rst_swap_count", 64'(swap_count), 64'd0);
    chk("rst_tready", 64'(tready), 64'd1);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_err_pulse", 64'(err_pulse), 64'd0);

    // Normal load then swap on data tlast.
    send_beat(32'h0403_0201, 1'b0);
    chk("load_b0_tready", 64'(tready), 64'd1);
    send_beat(32'h0807_0605, 1'b1);
    chk("armed_tready", 64'(tready), 64'd0);
    chk("armed_coeffs_hold", 64'(coeffs), 64'h0000_0000_0000_007F);
    mon_hs(1'b0);
    chk("armed_no_tlast_hold", 64'(coeffs), 64'h0000_0000_0000_007F);
    mon_hs(1'b1);
    chk("swap1_coeffs", 64'(coeffs), 64'h0807_0605_0403_0201);
    chk("swap1_count", 64'(swap_count), 64'd1);
    chk("swap1_settled", 64'(settled), 64'd0);
    for (int i = 0; i < 7; i++) mon_hs(1'b0);
    chk("settle7_settled", 64'(settled), 64'd0);
    chk("settle7_tready", 64'(tready), 64'd0);
    mon_hs(1'b0);
    chk("settle8_settled", 64'(settled), 64'd1);
    chk("settle8_tready", 64'(tready), 64'd1);

    // Single beat with tlast in IDLE is an error.
    send_beat(32'hDEAD_BEEF, 1'b1);
    chk("short_err_pulse", 64'(err_pulse), 64'd1);
    chk("short_err_count", 64'(err_count), 64'd1);
    chk("short_tready", 64'(tready), 64'd1);
    step();
    chk("short_pulse_drop", 64'(err_pulse), 64'd0);
    chk("short_coeffs_hold", 64'(coeffs), 64'h0807_0605_0403_0201);

    // Following load is accepted; swap via force_swap.
    send_beat(32'h1413_1211, 1'b0);
    send_beat(32'h1817_1615, 1'b1);
    chk("reload_armed", 64'(tready), 64'd0);
    fswap = 1'b1;
    step();
    fswap = 1'b0;
    chk("force_coeffs", 64'(coeffs), 64'h1817_1615_1413_1211);
    chk("force_count", 64'(swap_count), 64'd2);
    for (int i = 0; i < 8; i++) mon_hs(1'b0);
    chk("force_settled", 64'(settled), 64'd1);

    // Overlong frame: error after beat 2, third beat drained.
    send_beat(32'h0101_0101, 1'b0);
    send_beat(32'h0202_0202, 1'b0);
    chk("long_err_pulse", 64'(err_pulse), 64'd1);
    chk("long_err_count", 64'(err_count), 64'd2);
    chk("long_drain_tready", 64'(tready), 64'd1);
    send_beat(32'h0303_0303, 1'b1);
    chk("long_pulse_drop", 64'(err_pulse), 64'd0);
    chk("long_err_count2", 64'(err_count), 64'd2);
    chk("long_swap_count", 64'(swap_count), 64'd2);
    chk("long_coeffs_hold", 64'(coeffs), 64'h1817_1615_1413_1211);

    // force_swap and mon tlast are ignored in IDLE.
    fswap = 1'b1;
    step();
    fswap = 1'b0;
    mon_hs(1'b1);
    chk("idle_force_count", 64'(swap_count), 64'd2);
    chk("idle_force_coeffs", 64'(coeffs), 64'h1817_1615_1413_1211);
    chk("idle_force_tready", 64'(tready), 64'd1);

    // Coincident force_swap and data tlast give exactly one swap.
    send_beat(32'h2423_2221, 1'b0);
    send_beat(32'h2827_2625, 1'b1);
    fswap  = 1'b1;
    mon_hs(1'b1);
    fswap  = 1'b0;
    chk("both_count", 64'(swap_count), 64'd3);
    chk("both_coeffs", 64'(coeffs), 64'h2827_2625_2423_2221);
    step();
    chk("both_count_stable", 64'(swap_count), 64'd3);
    for (int i = 0; i < 8; i++) mon_hs(1'b0);
    chk("both_settled", 64'(settled), 64'd1);

    // Reset mid-load discards the partial frame.
    send_beat(32'h3333_3333, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_coeffs", 64'(coeffs), 64'h0000_0000_0000_007F);
    chk("midrst_swap_count", 64'(swap_count), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_tready", 64'(tready), 64'd1);
    send_beat(32'h4443_4241, 1'b0);
    chk("midrst_b0_tready", 64'(tready), 64'd1);
    send_beat(32'h4847_4645, 1'b1);
    chk("midrst_armed", 64'(tready), 64'd0);
    fswap = 1'b1;
    step();
    fswap = 1'b0;
    chk("midrst_swap_coeffs", 64'(coeffs), 64'h4847_4645_4443_4241);
    chk("midrst_swap_count2", 64'(swap_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
